// File: rtl/bpsk_modulator_if.sv
// Bit-stream handshake between the packet serializer (master) and the BPSK modulator (slave).
// One bit moves on every clock where bit_valid and bit_ready are both high.
interface bpsk_modulator_if;
    logic bit_data;
    logic bit_last;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_data, output bit_last, output bit_valid, input bit_ready);
    modport slave  (input bit_data, input bit_last, input bit_valid, output bit_ready);
endinterface

// File: rtl/bpsk_modulator.sv
// BPSK modulator: pulls bits from the serializer and emits signed 8-bit carrier samples
// from a 16-entry sine table, phase 0/180 deg per bit (NRZ or differential).
module bpsk_modulator #(
    parameter int unsigned SAMPLE_DIV     = 2,
    parameter int unsigned CYCLES_PER_BIT = 4,
    parameter bit          DIFF           = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    bpsk_modulator_if.slave     bit_if,
    output logic signed [7:0]   sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                underrun
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CYC_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_BIT - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         idx_q, idx_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               phase_q, phase_d;
    logic               last_q, last_d;
    logic signed [7:0]  sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               underrun_q, underrun_d;

    logic end_of_bit;
    logic xfer;

    function automatic logic signed [7:0] sin_lut(input logic [3:0] i);
        logic signed [7:0] v;
        case (i)
            4'd0:  v = 8'sd0;
            4'd1:  v = 8'sd49;
            4'd2:  v = 8'sd90;
            4'd3:  v = 8'sd117;
            4'd4:  v = 8'sd127;
            4'd5:  v = 8'sd117;
            4'd6:  v = 8'sd90;
            4'd7:  v = 8'sd49;
            4'd8:  v = 8'sd0;
            4'd9:  v = -8'sd49;
            4'd10: v = -8'sd90;
            4'd11: v = -8'sd117;
            4'd12: v = -8'sd127;
            4'd13: v = -8'sd117;
            4'd14: v = -8'sd90;
            default: v = -8'sd49;
        endcase
        return v;
    endfunction

    assign end_of_bit = (state_q == RUN) && (div_q == DIV_LAST) &&
                        (idx_q == 4'd15) && (cyc_q == CYC_LAST);
    assign xfer       = bit_if.bit_valid && bit_if.bit_ready;

    assign bit_if.bit_ready = (state_q == IDLE) || end_of_bit;
    assign busy             = (state_q == RUN);
    assign sample_out       = sample_q;
    assign sample_valid     = valid_q;
    assign underrun         = underrun_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        cyc_d      = cyc_q;
        phase_d    = phase_q;
        last_d     = last_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        underrun_d = 1'b0;

        // Table range is symmetric (+-127), so the negation cannot overflow.
        if (state_q == RUN && div_q == '0) begin
            sample_d = phase_q ? -sin_lut(idx_q) : sin_lut(idx_q);
            valid_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = RUN;
                    div_d   = '0;
                    idx_d   = '0;
                    cyc_d   = '0;
                    last_d  = bit_if.bit_last;
                    phase_d = DIFF ? (phase_q ^ bit_if.bit_data) : bit_if.bit_data;
                end
            end
            RUN: begin
                if (end_of_bit) begin
                    div_d = '0;
                    idx_d = '0;
                    cyc_d = '0;
                    if (xfer) begin
                        last_d  = bit_if.bit_last;
                        phase_d = DIFF ? (phase_q ^ bit_if.bit_data) : bit_if.bit_data;
                    end else begin
                        // Clearing phase here restarts the differential reference each packet.
                        state_d    = IDLE;
                        phase_d    = 1'b0;
                        underrun_d = ~last_q;
                    end
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (idx_q == 4'd15) begin
                        idx_d = '0;
                        cyc_d = cyc_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The last sample of a bit (SAMPLE_DIV==1) still goes out on the edge entering IDLE.
        if (state_d == IDLE && !valid_d) begin
            sample_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            cyc_q      <= '0;
            phase_q    <= 1'b0;
            last_q     <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            cyc_q      <= cyc_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Directed bench for bpsk_modulator: three instances (NRZ 2/1, differential 2/1, NRZ 1/3)
// driven one at a time; samples, strobes, busy, ready and underrun checked against constants.
module tb_bpsk_modulator;

    localparam int SIN_TBL [16] = '{0, 49, 90, 117, 127, 117, 90, 49,
                                    0, -49, -90, -117, -127, -117, -90, -49};

    logic clk;
    logic rst_n;

    bpsk_modulator_if if_a ();
    bpsk_modulator_if if_d ();
    bpsk_modulator_if if_f ();

    logic signed [7:0] so_a, so_d, so_f;
    logic sv_a, sv_d, sv_f;
    logic busy_a, busy_d, busy_f;
    logic ur_a, ur_d, ur_f;

    bpsk_modulator #(.SAMPLE_DIV(2), .CYCLES_PER_BIT(1), .DIFF(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bit_if(if_a),
        .sample_out(so_a), .sample_valid(sv_a), .busy(busy_a), .underrun(ur_a));

    bpsk_modulator #(.SAMPLE_DIV(2), .CYCLES_PER_BIT(1), .DIFF(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n), .bit_if(if_d),
        .sample_out(so_d), .sample_valid(sv_d), .busy(busy_d), .underrun(ur_d));

    bpsk_modulator #(.SAMPLE_DIV(1), .CYCLES_PER_BIT(3), .DIFF(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .bit_if(if_f),
        .sample_out(so_f), .sample_valid(sv_f), .busy(busy_f), .underrun(ur_f));

    int   sel;
    logic d_valid, d_data, d_last;

    assign if_a.bit_valid = (sel == 0) && d_valid;
    assign if_a.bit_data  = d_data;
    assign if_a.bit_last  = d_last;
    assign if_d.bit_valid = (sel == 1) && d_valid;
    assign if_d.bit_data  = d_data;
    assign if_d.bit_last  = d_last;
    assign if_f.bit_valid = (sel == 2) && d_valid;
    assign if_f.bit_data  = d_data;
    assign if_f.bit_last  = d_last;

    logic signed [7:0] m_out;
    logic m_valid, m_busy, m_ur, m_ready;

    always_comb begin
        case (sel)
            0: begin m_out = so_a; m_valid = sv_a; m_busy = busy_a; m_ur = ur_a; m_ready = if_a.bit_ready; end
            1: begin m_out = so_d; m_valid = sv_d; m_busy = busy_d; m_ur = ur_d; m_ready = if_d.bit_ready; end
            default: begin m_out = so_f; m_valid = sv_f; m_busy = busy_f; m_ur = ur_f; m_ready = if_f.bit_ready; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge, away from the active edge.
    int val_q[$];
    int t_q[$];
    int busy_n, rdy_run_n, ur_n, ur_cyc, first_xfer;

    always @(negedge clk) begin
        if (m_valid) begin
            val_q.push_back(int'(m_out));
            t_q.push_back(cyc);
        end
        if (m_busy) busy_n++;
        if (m_busy && m_ready) rdy_run_n++;
        if (m_ur) begin
            ur_n++;
            ur_cyc = cyc;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        val_q.delete();
        t_q.delete();
        busy_n     = 0;
        rdy_run_n  = 0;
        ur_n       = 0;
        ur_cyc     = -1;
        first_xfer = -1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Sends n bits back to back; bit i taken from bits[i] / lasts[i]. Inputs change at posedge+2.
    task automatic send(input logic [7:0] bits, input logic [7:0] lasts, input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            d_valid = 1'b1;
            d_data  = bits[i];
            d_last  = lasts[i];
            guard   = 0;
            while (!m_ready && guard < 300) begin
                step(1);
                guard++;
            end
            if (guard >= 300) check($sformatf("ready_timeout_bit%0d", i), 0, 1);
            if (first_xfer < 0) first_xfer = cyc + 1;
            step(1);
        end
        d_valid = 1'b0;
    endtask

    // Expected samples: SIN table per 16-sample block, negated where neg_mask bit is set.
    task automatic check_seq(input string tag, input int n_exp, input logic [3:0] neg_mask, input int gap);
        int n;
        check({tag, "_count"}, val_q.size(), n_exp);
        n = (val_q.size() < n_exp) ? val_q.size() : n_exp;
        for (int i = 0; i < n; i++) begin
            int e;
            e = neg_mask[i / 16] ? -SIN_TBL[i % 16] : SIN_TBL[i % 16];
            check($sformatf("%s_s%0d", tag, i), val_q[i], e);
        end
        for (int i = 1; i < n; i++) begin
            check($sformatf("%s_gap%0d", tag, i), t_q[i] - t_q[i-1], gap);
        end
        if (n > 0) check({tag, "_latency"}, t_q[0] - first_xfer, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        sel     = 0;
        d_valid = 1'b0;
        d_data  = 1'b0;
        d_last  = 1'b0;
        rst_n   = 1'b0;
        clear_mon();
        step(3);

        check("rst_sample", int'(so_a), 0);
        check("rst_valid", sv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_underrun", ur_a, 0);
        check("rst_ready", if_a.bit_ready, 1);
        rst_n = 1'b1;
        step(2);

        // Single bit 0, last: positive table once, 32 busy clocks, no underrun.
        clear_mon();
        send(8'b0, 8'b1, 1);
        step(40);
        check_seq("single", 16, 4'b0000, 2);
        check("single_busy", busy_n, 32);
        check("single_underrun", ur_n, 0);
        check("single_ready_after", m_ready, 1);
        check("single_idle_sample", int'(m_out), 0);

        // Bits 1,0 back to back: negated then positive, no gap, ready once per bit in RUN.
        clear_mon();
        send(8'b01, 8'b10, 2);
        step(40);
        check_seq("b2b", 32, 4'b0001, 2);
        check("b2b_busy", busy_n, 64);
        check("b2b_ready_in_run", rdy_run_n, 2);
        check("b2b_underrun", ur_n, 0);

        // Bit 1 not last, valid dropped: one underrun pulse on the first IDLE clock.
        clear_mon();
        send(8'b1, 8'b0, 1);
        step(40);
        check_seq("urun", 16, 4'b0001, 2);
        check("urun_count", ur_n, 1);
        check("urun_time", ur_cyc - first_xfer, 32);

        clear_mon();
        send(8'b1, 8'b1, 1);
        step(40);
        check_seq("nourun", 16, 4'b0001, 2);
        check("nourun_count", ur_n, 0);

        // Reset at clock 10 of a bit: outputs clear immediately, no strobes while held.
        clear_mon();
        send(8'b0, 8'b1, 1);
        step(9);
        check("midrst_busy_before", busy_a, 1);
        check("midrst_sample_before", int'(so_a), SIN_TBL[4]);
        rst_n = 1'b0;
        #1;
        check("midrst_sample", int'(so_a), 0);
        check("midrst_valid", sv_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_ready", if_a.bit_ready, 1);
        clear_mon();
        step(4);
        check("midrst_strobes", val_q.size(), 0);
        rst_n = 1'b1;
        step(2);
        clear_mon();
        send(8'b0, 8'b1, 1);
        step(40);
        check_seq("postrst", 16, 4'b0000, 2);

        // Differential: bits 1,1,0 -> phases 1,0,0; later single-bit packets restart at phase 0.
        sel = 1;
        step(1);
        clear_mon();
        send(8'b011, 8'b100, 3);
        step(40);
        check_seq("diff", 48, 4'b0001, 2);
        check("diff_busy", busy_n, 96);
        clear_mon();
        send(8'b1, 8'b1, 1);
        step(40);
        check_seq("diff_pkt2", 16, 4'b0001, 2);
        clear_mon();
        send(8'b1, 8'b1, 1);
        step(40);
        check_seq("diff_pkt3", 16, 4'b0001, 2);

        // SAMPLE_DIV=1, CYCLES_PER_BIT=3: 48 consecutive strobes, table three times.
        sel = 2;
        step(1);
        clear_mon();
        send(8'b0, 8'b1, 1);
        step(56);
        check_seq("div1", 48, 4'b0000, 1);
        check("div1_busy", busy_n, 48);
        check("div1_underrun", ur_n, 0);
        check("div1_idle_sample", int'(m_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
